fifo_port_arbiter: RTL and testbench

Round-robin write arbiter and read scheduler for the shared delayed-output FIFO. Up to NUM_REQ producers compete for the single FIFO write port. The block tags every accepted word with its source ID and issues FIFO reads for one consumer. It tracks the fixed FIFO read latency, so the consumer receives a single-cycle `rd_valid` strobe aligned with the FIFO output data and its source tag. It sits between the producer/consumer logic and the FIFO instance, and owns all of the FIFO's enable inputs.

---
 rtl/fifo_port_arbiter.sv | 133 +++++++++++++
 tb/tb_fifo_port_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_arbiter.sv
// Round-robin write arbiter and latency-tracking read scheduler for a shared
// delayed-output FIFO; tags every stored word with the producer that wrote it.
module fifo_port_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int READ_LATENCY = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              wr_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]              wr_gnt,
  input  logic                            rd_req,
  output logic                            rd_valid,
  output logic [DATA_WIDTH-1:0]           rd_data,
  output logic [$clog2(NUM_REQ)-1:0]      rd_src,
  output logic [$clog2(FIFO_DEPTH):0]     level,
  output logic                            fifo_write_en,
  output logic                            fifo_read_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  input  logic [DATA_WIDTH-1:0]           fifo_data_out,
  input  logic                            fifo_full,
  input  logic                            fifo_empty
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_any;

  logic [IDX_W-1:0] tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] tag_wr_ptr;
  logic [PTR_W-1:0] tag_rd_ptr;
  logic [IDX_W-1:0] pop_tag;

  logic [READ_LATENCY-1:0]            vld_sr;
  logic [READ_LATENCY-1:0][IDX_W-1:0] src_sr;

  // Producer index base+off, wrapped into 0..NUM_REQ-1.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    wr_gnt  = '0;
    // First set request at or after ptr wins; reset and full both block grants.
    if (rst_n && !fifo_full) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!gnt_any && wr_req[wrap_add(ptr, k)]) begin
          gnt_any = 1'b1;
          gnt_idx = wrap_add(ptr, k);
        end
      end
    end
    if (gnt_any) wr_gnt[gnt_idx] = 1'b1;
  end

  assign fifo_write_en = gnt_any;
  assign fifo_data_in  = gnt_any ? wr_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign fifo_read_en  = rst_n && rd_req && !fifo_empty && (level != '0);
  assign rd_data       = fifo_data_out;
  assign pop_tag       = tag_mem[tag_rd_ptr];
  assign rd_valid      = vld_sr[READ_LATENCY-1];
  assign rd_src        = src_sr[READ_LATENCY-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= wrap_add(gnt_idx, 1);
    end
  end

  // NOTE: the tag storage is deliberately not reset; only the pointers are,
  // and no entry is read before it has been written.
  always_ff @(posedge clk) begin
    if (fifo_write_en) tag_mem[tag_wr_ptr] <= gnt_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (fifo_write_en) tag_wr_ptr <= ptr_inc(tag_wr_ptr);
      if (fifo_read_en)  tag_rd_ptr <= ptr_inc(tag_rd_ptr);
    end
  end

  // Valid/tag delay line matched to the FIFO read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      src_sr <= '0;
    end else begin
      vld_sr[0] <= fifo_read_en;
      src_sr[0] <= fifo_read_en ? pop_tag : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        src_sr[i] <= src_sr[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({fifo_write_en, fifo_read_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Self-checking bench for fifo_port_arbiter: a behavioural delayed-output FIFO,
// a grant table, and a scoreboard of expected read returns.
module tb_fifo_port_arbiter;
  localparam int N     = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;
  localparam int L     = 5;
  localparam int IW    = 2;
  localparam int LW    = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    wr_req = '0;
  logic [N*DW-1:0] wr_data = '0;
  logic [N-1:0]    wr_gnt;
  logic            rd_req = 1'b0;
  logic            rd_valid;
  logic [DW-1:0]   rd_data;
  logic [IW-1:0]   rd_src;
  logic [LW-1:0]   level;
  logic            fifo_write_en, fifo_read_en;
  logic [DW-1:0]   fifo_data_in, fifo_data_out;
  logic            fifo_full, fifo_empty;
  logic            force_full = 1'b0;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .READ_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_src(rd_src), .level(level),
    .fifo_write_en(fifo_write_en), .fifo_read_en(fifo_read_en), .fifo_data_in(fifo_data_in),
    .fifo_data_out(fifo_data_out), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  // Behavioural FIFO with L-cycle read latency.
  logic [DW-1:0] f_mem [DEPTH];
  logic [DW-1:0] f_pipe [L];
  int            f_wp, f_rp, f_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wp  <= 0;
      f_rp  <= 0;
      f_cnt <= 0;
      for (int i = 0; i < L; i++) f_pipe[i] <= '0;
    end else begin
      if (fifo_write_en) begin
        f_mem[f_wp] <= fifo_data_in;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (fifo_read_en) begin
        f_pipe[0] <= f_mem[f_rp];
        f_rp <= (f_rp + 1) % DEPTH;
      end else begin
        f_pipe[0] <= '0;
      end
      for (int i = 1; i < L; i++) f_pipe[i] <= f_pipe[i-1];
      f_cnt <= f_cnt + int'(fifo_write_en) - int'(fifo_read_en);
    end
  end

  assign fifo_data_out = f_pipe[L-1];
  assign fifo_full     = (f_cnt == DEPTH) || force_full;
  assign fifo_empty    = (f_cnt == 0);

  typedef struct {
    logic [N-1:0]    req;
    logic            ff;
    logic [N*DW-1:0] data;
    logic [N-1:0]    gnt;
  } vec_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] src;
  } exp_t;

  exp_t sb[$];
  int   due[$];
  int   cyc = 0;
  int   m_ptr = 0;
  int   m_level = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req);
    if ((f_cnt == DEPTH) || force_full) return '0;
    for (int k = 0; k < N; k++) begin
      if (req[(m_ptr + k) % N]) return N'(1) << ((m_ptr + k) % N);
    end
    return '0;
  endfunction

  task automatic model_reset();
    sb.delete();
    due.delete();
    m_ptr   = 0;
    m_level = 0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model.
  task automatic step(input logic [N-1:0] req, input logic [N*DW-1:0] data, input logic rd,
                      input logic ff, input logic [N-1:0] exp_gnt, input bit pulse_rst = 1'b0);
    logic exp_rd, exp_vld;
    int   gi;
    exp_t e;
    wr_req = req; wr_data = data; rd_req = rd; force_full = ff;
    @(negedge clk);
    check("wr_gnt", 32'(wr_gnt), 32'(exp_gnt));
    check("fifo_write_en", 32'(fifo_write_en), 32'(|exp_gnt));
    gi = -1;
    for (int k = 0; k < N; k++) if (exp_gnt[k]) gi = k;
    if (gi >= 0) check("fifo_data_in", 32'(fifo_data_in), 32'(data[gi*DW +: DW]));
    exp_rd = rd && (f_cnt != 0) && (m_level != 0);
    check("fifo_read_en", 32'(fifo_read_en), 32'(exp_rd));
    check("level", 32'(level), 32'(m_level));
    exp_vld = (due.size() > 0) && (due[0] == cyc);
    check("rd_valid", 32'(rd_valid), 32'(exp_vld));
    if (exp_vld) begin
      void'(due.pop_front());
      e = sb.pop_front();
      check("rd_data", 32'(rd_data), 32'(e.data));
      check("rd_src", 32'(rd_src), 32'(e.src));
    end
    if (gi >= 0) begin
      sb.push_back('{data[gi*DW +: DW], IW'(gi)});
      m_level++;
      m_ptr = (gi + 1) % N;
    end
    if (exp_rd) begin
      m_level--;
      due.push_back(cyc + L);
    end
    cyc++;
    if (pulse_rst) begin
      #1 rst_n = 1'b0;
      wr_req = '1;
      #1;
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_rd_src", 32'(rd_src), 32'd0);
      check("rst_wr_gnt", 32'(wr_gnt), 32'd0);
      wr_req = '0;
      #1 rst_n = 1'b1;
      model_reset();
    end
    @(posedge clk); #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0; wr_req = '1; rd_req = 1'b1;
    #2;
    check("reset_wr_gnt", 32'(wr_gnt), 32'd0);
    check("reset_write_en", 32'(fifo_write_en), 32'd0);
    check("reset_read_en", 32'(fifo_read_en), 32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    check("reset_rd_src", 32'(rd_src), 32'd0);
    @(negedge clk); #1;
    rst_n = 1'b1; wr_req = '0; rd_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  vec_t vec [15];

  initial begin
    vec[0]  = '{4'b1111, 1'b0, 16'h3210, 4'b0001};
    vec[1]  = '{4'b1111, 1'b0, 16'h7654, 4'b0010};
    vec[2]  = '{4'b1111, 1'b0, 16'hBA98, 4'b0100};
    vec[3]  = '{4'b1111, 1'b0, 16'hFEDC, 4'b1000};
    vec[4]  = '{4'b1111, 1'b0, 16'h1357, 4'b0001};
    vec[5]  = '{4'b1111, 1'b0, 16'h2468, 4'b0010};
    vec[6]  = '{4'b1111, 1'b0, 16'h9ACE, 4'b0100};
    vec[7]  = '{4'b1111, 1'b0, 16'h5BDF, 4'b1000};
    vec[8]  = '{4'b0110, 1'b1, 16'h1111, 4'b0000};
    vec[9]  = '{4'b0110, 1'b0, 16'hC3A5, 4'b0010};
    vec[10] = '{4'b1001, 1'b0, 16'h0F0F, 4'b1000};
    vec[11] = '{4'b0000, 1'b0, 16'h0000, 4'b0000};
    vec[12] = '{4'b0101, 1'b0, 16'h6E2D, 4'b0001};
    vec[13] = '{4'b0101, 1'b0, 16'h48B1, 4'b0100};
    vec[14] = '{4'b0011, 1'b0, 16'h79C4, 4'b0001};

    @(posedge clk); #1;
    reset_pulse();

    // Single write from producer 2, consumer reading from cycle 2 on;
    // later cycles also cover reads requested with nothing stored.
    step(4'b0100, 16'h0A00, 1'b0, 1'b0, 4'b0100);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000);
    for (int c = 2; c < 12; c++) step(4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000);
    check("single_level", 32'(level), 32'd0);
    check("empty_read_en", 32'(fifo_read_en), 32'd0);

    // Round-robin fairness from reset, then mixed request patterns.
    reset_pulse();
    for (int r = 0; r < 8; r++) step(vec[r].req, vec[r].data, 1'b0, vec[r].ff, vec[r].gnt);
    check("rr_level", 32'(level), 32'd8);
    for (int r = 8; r < 15; r++) step(vec[r].req, vec[r].data, 1'b0, vec[r].ff, vec[r].gnt);

    // Fill to 16, hold requests while full, release with one read.
    step(4'b0001, 16'h000A, 1'b0, 1'b0, 4'b0001);
    step(4'b0001, 16'h000B, 1'b0, 1'b0, 4'b0001);
    step(4'b0001, 16'h000C, 1'b0, 1'b0, 4'b0001);
    check("full_level", 32'(level), 32'd16);
    for (int c = 0; c < 3; c++) step(4'b1010, 16'hD0E0, 1'b0, 1'b0, 4'b0000);
    step(4'b1010, 16'hD0E0, 1'b1, 1'b0, 4'b0000);
    step(4'b1010, 16'hD0E0, 1'b0, 1'b0, 4'b0010);

    // Drain everything; the scoreboard checks order and tags.
    for (int c = 0; c < DEPTH + L + 1; c++) step(4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000);
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_level", 32'(level), 32'd0);

    // Producer 0 and consumer active together.
    for (int k = 0; k < 10; k++) step(4'b0001, 16'(k + 3), 1'b1, 1'b0, rr_pick(4'b0001));
    check("traffic_level", 32'(level), 32'd1);
    for (int c = 0; c < L + 1; c++) step(4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000);
    check("traffic_sb_empty", 32'(sb.size()), 32'd0);

    // Async reset while three reads are in flight.
    for (int k = 0; k < 3; k++) step(4'b0100, 16'(k + 5) << 8, 1'b0, 1'b0, rr_pick(4'b0100));
    for (int k = 0; k < 3; k++) step(4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000, 1'b1);
    for (int c = 0; c < 8; c++) step(4'b0000, 16'h0000, 1'b1, 1'b0, 4'b0000);
    step(4'b1111, 16'h4321, 1'b0, 1'b0, 4'b0001);
    step(4'b0000, 16'h0000, 1'b0, 1'b0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
